sd_modulator_core: RTL and testbench
====================================

Name: sd_modulator_core

Overview:
- First-order sigma-delta (PDM) modulator core, directly downstream of the AXI-Lite register block.
- Consumes that block's `enable` and `value` outputs and produces a 1-bit pulse-density stream.
- Input value is sampled only at frame boundaries. Within each frame of 2^DATA_WIDTH output bits, the count of ones is exactly the sampled value.
- Bit rate is aclk/CLK_DIV.

Parameters:
- DATA_WIDTH, 8, modulator input width taken from value[DATA_WIDTH-1:0]; legal range 8..16.
- CLK_DIV, 4, aclk cycles per output bit; legal range >= 1.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous assertion, active-low
- enable  in  1  core enable from register block (1 = run)
- value  in  32  modulator input; only bits [DATA_WIDTH-1:0] are used, upper bits ignored
- pdm_out  out  1  PDM bit stream, registered
- pdm_tick  out  1  1-cycle pulse at the edge where pdm_out takes a new bit
- frame_start  out  1  1-cycle pulse at the edge where bit 0 of a frame is driven
- busy  out  1  high whenever state != IDLE

Behaviour:

Reset:
- aresetn low forces immediately (no clock edge needed): state=IDLE, pdm_out=0, pdm_tick=0, frame_start=0, busy=0.
- It also clears internal registers: acc=0, x_reg=0, div_cnt=0, bit_cnt=0.

Internal registers:
- acc: DATA_WIDTH bits, phase accumulator.
- x_reg: DATA_WIDTH bits, latched input.
- div_cnt: 0..CLK_DIV-1.
- bit_cnt: 0..2^DATA_WIDTH-1.

Bit step with input x:
- {carry, acc_next} = acc + x, computed at DATA_WIDTH+1 bits.
- On each step: pdm_out <= carry, acc <= acc_next, pdm_tick <= 1.
- pdm_tick is 0 at every other edge.

State machine (IDLE, RUN, DRAIN); enable is sampled on aclk:
- IDLE, enable=1 -> RUN, start frame:
  - x_reg <= value[DATA_WIDTH-1:0].
  - Bit step using x = value (acc is 0).
  - div_cnt <= 0, bit_cnt <= 0, frame_start <= 1.
  - busy is 1 from this edge.
- Period boundary is an edge with div_cnt == CLK_DIV-1 in RUN or DRAIN. Otherwise div_cnt increments.
- Boundary with bit_cnt < 2^DATA_WIDTH-1:
  - Bit step using x = x_reg.
  - bit_cnt++, div_cnt <= 0.
- Boundary with bit_cnt == 2^DATA_WIDTH-1 (frame end, acc is 0 here by construction):
  - In RUN: start a new frame exactly as on IDLE->RUN (re-latch value, frame_start pulse).
  - In DRAIN: -> IDLE, pdm_out <= 0, acc <= 0, no pdm_tick, busy <= 0.
- RUN, enable=0 -> DRAIN. Counting and bit output continue unchanged; the current frame always completes.
- DRAIN, enable=1 -> RUN with no restart: no frame_start, counters untouched.
- If enable changes on the same edge as a frame-end boundary, the state held before that edge decides the frame-end action; the enable transition then applies from the next edge.

Guarantees:
- Each bit is held for exactly CLK_DIV cycles.
- Each complete frame contains exactly x_reg ones.
- Value writes mid-frame take effect only at the next frame start.
- With CLK_DIV=1, every edge in RUN/DRAIN is a boundary.
- Reset asserted mid-frame aborts immediately. After release, the core restarts from IDLE and waits for enable.

Test Plan:
1. Reset check: hold aresetn=0 with random enable/value -> pdm_out=pdm_tick=frame_start=busy=0. Assert reset between edges -> outputs go 0 without a clock edge.
2. DATA_WIDTH=8, CLK_DIV=4, value=0x40, enable=1 for 2 frames:
   - frame_start every 1024 cycles; pdm_tick every 4 cycles.
   - Bit pattern repeats 0,0,0,1; exactly 64 ones per 256 bits.
3. value=0x40, then write 0xC0 at bit 100 -> current frame still 64 ones; next frame (after frame_start) 192 ones.
4. Extremes:
   - value=0x00 -> all bits 0, busy=1.
   - value=0xFF -> 255 ones per frame, single 0 at bit 0.
   - value=0xABCD00FF -> identical to 0xFF (upper bits ignored).
5. Drain/resume:
   - enable=0 at bit 10 -> busy stays 1 until frame end (1024 cycles after frame_start), then pdm_out=0, busy=0, no further pdm_tick.
   - Separate run: re-enable at bit 50 of DRAIN -> no extra frame_start, frame ones count unchanged.
6. Async reset at bit 130 of a frame -> all outputs 0 immediately. Release with enable=1 -> frame_start on the next edge, fresh 256-bit frame with correct ones count.

Source files
------------

// File: rtl/sd_modulator_core.sv
// First-order sigma-delta (PDM) modulator core.
// Latches value[DATA_WIDTH-1:0] at each frame start and emits 2^DATA_WIDTH
// bits, one every CLK_DIV aclk cycles. Each frame carries exactly the latched
// count of ones.
module sd_modulator_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic [31:0] value,
  output logic        pdm_out,
  output logic        pdm_tick,
  output logic        frame_start,
  output logic        busy
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] acc, acc_n;
  logic [DATA_WIDTH-1:0] x_reg, x_reg_n;
  logic [DATA_WIDTH-1:0] bit_cnt, bit_cnt_n;
  logic [DIV_W-1:0]      div_cnt, div_cnt_n;
  logic                  pdm_out_n, pdm_tick_n, frame_start_n;

  logic [DATA_WIDTH-1:0] x_in;
  logic [DATA_WIDTH:0]   step_sum;
  logic [DATA_WIDTH:0]   start_sum;
  logic                  boundary, frame_end, start;
  logic                  unused_value_hi;

  assign x_in            = value[DATA_WIDTH-1:0];
  assign unused_value_hi = ^value[31:DATA_WIDTH];

  // acc is zero at every frame start, so the first step only needs x.
  assign start_sum = {1'b0, x_in};
  assign step_sum  = {1'b0, acc} + {1'b0, x_reg};
  assign boundary  = (state != IDLE) && (div_cnt == DIV_LAST);
  assign frame_end = boundary && (bit_cnt == '1);
  assign start     = ((state == IDLE) && enable) || (frame_end && (state == RUN));
  assign busy      = (state != IDLE);

  // Next-state and datapath: frame start, bit step, divider count, drain exit.
  always_comb begin
    state_n       = state;
    acc_n         = acc;
    x_reg_n       = x_reg;
    bit_cnt_n     = bit_cnt;
    div_cnt_n     = div_cnt;
    pdm_out_n     = pdm_out;
    pdm_tick_n    = 1'b0;
    frame_start_n = 1'b0;

    if (start) begin
      x_reg_n       = x_in;
      acc_n         = start_sum[DATA_WIDTH-1:0];
      pdm_out_n     = start_sum[DATA_WIDTH];
      pdm_tick_n    = 1'b1;
      frame_start_n = 1'b1;
      div_cnt_n     = '0;
      bit_cnt_n     = '0;
      state_n       = RUN;
    end else if (state != IDLE) begin
      if (!boundary) begin
        div_cnt_n = div_cnt + 1'b1;
      end else if (!frame_end) begin
        acc_n      = step_sum[DATA_WIDTH-1:0];
        pdm_out_n  = step_sum[DATA_WIDTH];
        pdm_tick_n = 1'b1;
        bit_cnt_n  = bit_cnt + 1'b1;
        div_cnt_n  = '0;
      end else begin
        // Frame end while draining: park the line low and go idle.
        state_n   = IDLE;
        pdm_out_n = 1'b0;
        acc_n     = '0;
        div_cnt_n = '0;
        bit_cnt_n = '0;
      end
      // On a frame-end edge the held state already decided the action;
      // an enable change is picked up on the following edge instead.
      if (!frame_end) begin
        if ((state == RUN) && !enable)
          state_n = DRAIN;
        else if ((state == DRAIN) && enable)
          state_n = RUN;
      end
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      acc         <= '0;
      x_reg       <= '0;
      bit_cnt     <= '0;
      div_cnt     <= '0;
      pdm_out     <= 1'b0;
      pdm_tick    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      acc         <= acc_n;
      x_reg       <= x_reg_n;
      bit_cnt     <= bit_cnt_n;
      div_cnt     <= div_cnt_n;
      pdm_out     <= pdm_out_n;
      pdm_tick    <= pdm_tick_n;
      frame_start <= frame_start_n;
    end
  end

endmodule

// File: tb/tb_sd_modulator_core.sv
// Scoreboard bench for sd_modulator_core (DATA_WIDTH=8, CLK_DIV=4).
// Stimulus pushes the expected ones count and first 8 bits of each frame
// that should complete; the monitor rebuilds frames from pdm_tick/pdm_out.
module tb_sd_modulator_core;

  localparam int unsigned DW      = 8;
  localparam int unsigned CLK_DIV = 4;
  localparam int          NBITS   = 1 << DW;
  localparam int          FRAME_CYC = NBITS * CLK_DIV;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic [31:0] value;
  logic        pdm_out, pdm_tick, frame_start, busy;

  sd_modulator_core #(
    .DATA_WIDTH(DW),
    .CLK_DIV   (CLK_DIV)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .enable     (enable),
    .value      (value),
    .pdm_out    (pdm_out),
    .pdm_tick   (pdm_tick),
    .frame_start(frame_start),
    .busy       (busy)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int         ones;
    logic [7:0] head;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int ones, input logic [7:0] head);
    exp_t e;
    e.ones = ones;
    e.head = head;
    q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  int         cyc = 0;
  int         last_tick = 0;
  bit         have_last = 0;
  bit         in_frame = 0;
  int         nbits = 0;
  int         nones = 0;
  logic [7:0] head = '0;

  task close_frame();
    exp_t e;
    check("frame_len", nbits, NBITS);
    if (q.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      e = q.pop_front();
      check("frame_ones", nones, e.ones);
      check("frame_head", int'(head), int'(e.head));
    end
    in_frame = 0;
  endtask

  always @(negedge aclk) begin
    cyc++;
    if (!aresetn) begin
      in_frame  = 0;
      have_last = 0;
    end else if (!busy) begin
      check("idle_tick", int'(pdm_tick), 0);
      check("idle_out", int'(pdm_out), 0);
      if (in_frame) close_frame();
      have_last = 0;
    end else if (pdm_tick) begin
      if (have_last) check("tick_gap", cyc - last_tick, CLK_DIV);
      have_last = 1;
      last_tick = cyc;
      if (frame_start) begin
        if (in_frame) close_frame();
        in_frame = 1;
        nbits = 0;
        nones = 0;
        head  = '0;
      end
      if (in_frame) begin
        if (nbits < 8) head[nbits] = pdm_out;
        nones += int'(pdm_out);
        nbits++;
      end
    end else begin
      check("fs_without_tick", int'(frame_start), 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_fs(output longint t);
    int n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!frame_start && n < FRAME_CYC + 200);
    check("frame_start_seen", int'(frame_start), 1);
    t = longint'($time);
  endtask

  task automatic wait_idle(output longint t);
    int n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (busy && n < FRAME_CYC + 200);
    check("drain_done", int'(busy), 0);
    t = longint'($time);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge aclk);
  endtask

  initial begin
    longint t_fs, t_end;

    // Reset with random inputs: everything held low.
    aresetn = 1'b0;
    enable  = 1'b0;
    value   = '0;
    for (int i = 0; i < 3; i++) begin
      enable = 1'($urandom_range(0, 1));
      value  = $urandom;
      @(negedge aclk);
      check("rst_out", int'(pdm_out), 0);
      check("rst_tick", int'(pdm_tick), 0);
      check("rst_fs", int'(frame_start), 0);
      check("rst_busy", int'(busy), 0);
    end
    enable  = 1'b0;
    value   = '0;
    aresetn = 1'b1;
    cycles(5);

    // 0x40: pattern 0,0,0,1 -> 64 ones; three frames.
    value  = 32'h40;
    enable = 1'b1;
    push(64, 8'h88);
    push(64, 8'h88);
    push(64, 8'h88);
    wait_fs(t_fs);
    wait_fs(t_end);
    check("frame_period", int'((t_end - t_fs) / 10), FRAME_CYC);
    wait_fs(t_fs);

    // Mid-frame write at bit 100 only affects the next frame: 0xC0 -> 192.
    cycles(100 * CLK_DIV);
    value = 32'hC0;
    push(192, 8'hEE);
    wait_fs(t_fs);

    value = 32'h00;
    push(0, 8'h00);
    wait_fs(t_fs);
    cycles(100);
    check("zero_busy", int'(busy), 1);
    check("zero_out", int'(pdm_out), 0);

    value = 32'hFF;
    push(255, 8'hFE);
    wait_fs(t_fs);

    value = 32'hABCD00FF;
    push(255, 8'hFE);
    wait_fs(t_fs);

    // Disable at bit 10: frame completes, then idle 1024 cycles after start.
    cycles(10 * CLK_DIV);
    enable = 1'b0;
    wait_idle(t_end);
    check("drain_len", int'((t_end - t_fs) / 10), FRAME_CYC);
    cycles(20);
    check("idle_busy", int'(busy), 0);

    // Drain then resume at bit 50: no restart, frame stays intact.
    value  = 32'h40;
    enable = 1'b1;
    push(64, 8'h88);
    wait_fs(t_fs);
    cycles(10 * CLK_DIV);
    enable = 1'b0;
    cycles(40 * CLK_DIV);
    enable = 1'b1;
    cycles(10 * CLK_DIV);
    value = 32'h20;
    wait_fs(t_end);
    check("resume_period", int'((t_end - t_fs) / 10), FRAME_CYC);

    // Async reset at bit 130 of the 0x20 frame, between clock edges.
    cycles(130 * CLK_DIV);
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check("async_out", int'(pdm_out), 0);
    check("async_tick", int'(pdm_tick), 0);
    check("async_fs", int'(frame_start), 0);
    check("async_busy", int'(busy), 0);
    cycles(3);
    aresetn = 1'b1;
    push(32, 8'h80);
    @(posedge aclk);
    #1;
    check("restart_fs", int'(frame_start), 1);
    check("restart_tick", int'(pdm_tick), 1);
    check("restart_busy", int'(busy), 1);
    @(negedge aclk);
    enable = 1'b0;
    wait_idle(t_end);
    cycles(10);
    check("sb_leftover", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
